ssm_bit_window: RTL and testbench
=================================

# ssm_bit_window

Bitstream alignment buffer that sits directly upstream of the per-SSM entropy-group parser. It accepts fixed-width words from the substream FIFO and always presents a left-aligned 128-bit `suffix` window. Each time the parser reports how many bits it used (`numbits`), the window advances by exactly that many bits. Advancing and refilling happen in the same cycle, so one ECG can be parsed per clock once the buffer is primed.

## Interface

Parameters:
- `IN_W`, 64: width of an input word. Legal values are 32 and 64.
- `BUF_W`, 256: internal buffer width in bits. Must be at least 128 + `IN_W`.
- `POS_W`, 24: width of the consumed-bit position counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush at a slice or substream boundary.
- `in_data`  in  IN_W  bitstream word; bit `IN_W-1` is the first bit in stream order.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the buffer can accept a word this cycle.
- `suffix`  out  128  window; bit 127 is the next unconsumed bit.
- `suffix_valid`  out  1  `fill` ≥ 128.
- `consume_valid`  in  1  the parser consumed bits from the current window.
- `consume_bits`  in  8  number of bits consumed (the parser's `numbits`), 0..128.
- `fill`  out  9  number of valid bits held in the buffer.
- `bit_pos`  out  POS_W  total bits consumed since reset or `clear`; wraps modulo 2^POS_W.
- `err_overrun`  out  1  sticky illegal-consume flag.

## Operation

Storage:
- Register `buf[BUF_W-1:0]`, MSB-aligned; valid bits occupy `buf[BUF_W-1 -: fill]`.
- `suffix = buf[BUF_W-1 -: 128]`. The output is driven regardless of `suffix_valid`.
- Bits below the `fill` boundary are always zero, so a partially filled window reads zero-padded.

Per-cycle update. Values are taken from registered state, consume is applied first, then append:
- Consume is legal when `consume_valid && suffix_valid && consume_bits ≤ 128`. Then `buf' = buf << consume_bits` (zero fill) and `fill' = fill − consume_bits`.
- Consume is illegal when `consume_valid` is high and either `suffix_valid` is 0 or `consume_bits > 128`. Then there is no shift, `err_overrun` sets, and `fill` and `bit_pos` are unchanged.
- `consume_bits = 0` with `consume_valid` high is a legal no-op.
- Append happens when `in_valid && in_ready`. `in_data` is written at `buf'[BUF_W-1-fill' -: IN_W]` and `fill'' = fill' + IN_W`.
- `in_ready = (fill ≤ BUF_W − IN_W)` is computed from the registered `fill` only. There is no combinational path from `consume_*` to `in_ready`. Overflow is therefore impossible, because consume can only reduce `fill`.
- `bit_pos` increments by `consume_bits` on every legal consume.

Clear and reset:
- `clear` has priority over consume and append in the same cycle. It sets `buf`, `fill` and `bit_pos` to 0 and leaves `err_overrun` unchanged.
- `err_overrun` is cleared only by `rst`.
- `rst` values: `buf=0`, `fill=0`, `bit_pos=0`, `err_overrun=0`. Outputs follow: `suffix=0`, `suffix_valid=0`, `in_ready=1`.
- Reset asserted mid-stream discards all buffered bits immediately and asynchronously.

Width rules:
- Shift amount is a 0..128 barrel shift.
- `fill` arithmetic is 9-bit unsigned and never exceeds `BUF_W`.
- `bit_pos` arithmetic is modulo 2^POS_W.

## Timing

- Latency: a word accepted at edge N is visible in `suffix` and `fill` after edge N; a consume at edge N shows the shifted window after edge N.
- Priming with `IN_W = 64`: two accepted words are needed. `suffix_valid` rises in the cycle after the second accept.
- Steady state: one consume per cycle is sustainable while average `consume_bits` ≤ `IN_W`.
- When consume and append occur in the same cycle, the appended word lands directly after the post-shift data.
- Handshakes:
  - `in_data` must stay stable while `in_valid && !in_ready`.
  - `consume_valid` is a single-cycle qualifier with no ready signal.
  - The parser must sample `suffix` only when `suffix_valid` is high.
- The window-advance path is registered-to-registered; there is no combinational loop through `suffix`.

## Test plan

- **Prime:** after reset, push `in_data` 0xF0F0_F0F0_F0F0_F0F0 then 0x1234_5678_9ABC_DEF0.
  - After the first word: `fill=64`, `suffix_valid=0`.
  - After the second word: `fill=128`, `suffix_valid=1`, `suffix=0xF0F0F0F0F0F0F0F0_123456789ABCDEF0`.
- **Consume + append same cycle:** with `fill=128`, `consume_bits=5` and `in_valid` high with 0xFFFF_FFFF_FFFF_FFFF.
  - Result: `fill=187`, `bit_pos=5`.
  - `suffix[127:0]` equals the old window shifted left by 5, with bits [4:0] = 5'b11111.
- **Backpressure:** push words with no consumes.
  - `in_ready` drops once `fill=256`; a held `in_valid` word is not lost.
  - After `consume_bits=100`, `fill=156`, `in_ready=1`, and the held word is appended next cycle (`fill=220`).
- **Illegal consume:**
  - `consume_bits=129` with `fill=200`: `err_overrun=1`, `fill=200` unchanged.
  - Separately, a consume with `fill=64`: `err_overrun=1`, no shift.
- **Clear priority:** `clear`, `consume_valid` and `in_valid` all high together.
  - Next cycle: `fill=0`, `bit_pos=0`, `suffix=0`, `err_overrun` unchanged.
- **Random stream:** a 10k-bit random stream with random `consume_bits` in 1..128 and random `in_valid` gaps.
  - The concatenation of the consumed prefixes equals the input stream bit-exactly.
  - `bit_pos` equals the total consumed modulo 2^24.

Source files
------------

// File: rtl/ssm_bit_window.sv
// Bitstream alignment buffer that feeds the entropy-group parser with a left-aligned
// 128-bit window, advancing by the parser's reported bit count and refilling in the same cycle.
module ssm_bit_window #(
  parameter int IN_W  = 64,
  parameter int BUF_W = 256,
  parameter int POS_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [127:0]       suffix,
  output logic               suffix_valid,
  input  logic               consume_valid,
  input  logic [7:0]         consume_bits,
  output logic [8:0]         fill,
  output logic [POS_W-1:0]   bit_pos,
  output logic               err_overrun
);

  localparam logic [8:0] READY_MAX = 9'(BUF_W - IN_W);
  localparam logic [8:0] WORD_BITS = 9'(IN_W);

  logic [BUF_W-1:0] data_buf;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] word_ext;
  logic [BUF_W-1:0] buf_next;
  logic [8:0]       fill_q;
  logic [8:0]       fill_shift;
  logic [8:0]       fill_next;
  logic             consume_ok;
  logic             consume_bad;
  logic             do_append;

  // in_ready depends on registered fill only, so the parser cannot create a loop through it
  assign in_ready     = (fill_q <= READY_MAX);
  assign suffix_valid = (fill_q >= 9'd128);
  assign suffix       = data_buf[BUF_W-1 -: 128];
  assign fill         = fill_q;

  assign consume_ok  = consume_valid && suffix_valid && (consume_bits <= 8'd128);
  assign consume_bad = consume_valid && !consume_ok;
  assign do_append   = in_valid && in_ready;

  // Shift out consumed bits first, then drop the new word right behind the remaining data
  always_comb begin
    shifted    = data_buf;
    fill_shift = fill_q;
    if (consume_ok) begin
      shifted    = data_buf << consume_bits;
      fill_shift = fill_q - {1'b0, consume_bits};
    end
    word_ext  = {in_data, {(BUF_W-IN_W){1'b0}}} >> fill_shift;
    buf_next  = shifted;
    fill_next = fill_shift;
    if (do_append) begin
      buf_next  = shifted | word_ext;
      fill_next = fill_shift + WORD_BITS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_buf    <= '0;
      fill_q      <= '0;
      bit_pos     <= '0;
      err_overrun <= 1'b0;
    end else if (clear) begin
      data_buf <= '0;
      fill_q   <= '0;
      bit_pos  <= '0;
    end else begin
      data_buf <= buf_next;
      fill_q   <= fill_next;
      if (consume_ok) begin
        bit_pos <= bit_pos + POS_W'(consume_bits);
      end
      if (consume_bad) begin
        err_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssm_bit_window.sv
// Self-checking bench for ssm_bit_window: directed scenarios plus a random stream,
// checked against a bit-queue model of the buffer contents.
module tb_ssm_bit_window;

  localparam int IN_W  = 64;
  localparam int BUF_W = 256;
  localparam int POS_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     suffix;
  logic             suffix_valid;
  logic             consume_valid;
  logic [7:0]       consume_bits;
  logic [8:0]       fill;
  logic [POS_W-1:0] bit_pos;
  logic             err_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of buffered bits in stream order, consumed position, sticky error
  bit          mq[$];
  int unsigned mpos;
  bit          merr;

  ssm_bit_window #(.IN_W(IN_W), .BUF_W(BUF_W), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .suffix(suffix), .suffix_valid(suffix_valid),
    .consume_valid(consume_valid), .consume_bits(consume_bits),
    .fill(fill), .bit_pos(bit_pos), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    mpos = 0;
    merr = 1'b0;
  endtask

  task automatic model_step();
    bit ready_m;
    bit sv_m;
    ready_m = (mq.size() <= BUF_W - IN_W);
    sv_m    = (mq.size() >= 128);
    if (clear) begin
      mq.delete();
      mpos = 0;
    end else begin
      if (consume_valid) begin
        if (sv_m && consume_bits <= 8'd128) begin
          repeat (int'(consume_bits)) void'(mq.pop_front());
          mpos = mpos + consume_bits;
        end else begin
          merr = 1'b1;
        end
      end
      if (in_valid && ready_m)
        for (int i = IN_W-1; i >= 0; i--) mq.push_back(in_data[i]);
    end
  endtask

  function automatic logic [127:0] model_suffix();
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < 128 && i < mq.size(); i++) s[127-i] = mq[i];
    return s;
  endfunction

  function automatic logic [POS_W-1:0] model_pos();
    return mpos[POS_W-1:0];
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; in_valid = 0; in_data = '0; consume_valid = 0; consume_bits = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (suffix !== 128'd0) begin n_fail++; $display("[TB] FAIL reset_suffix got=%h exp=0", suffix); end
    n_checks++; if (suffix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_suffix_valid got=%b exp=0", suffix_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (fill !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_fill got=%0d exp=0", fill); end
    n_checks++; if (bit_pos !== '0) begin n_fail++; $display("[TB] FAIL reset_bit_pos got=%0d exp=0", bit_pos); end
    n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got=%b exp=0", err_overrun); end
  endtask

  task automatic test_prime();
    in_valid = 1; in_data = 64'hF0F0_F0F0_F0F0_F0F0;
    tick();
    n_checks++; if (fill !== 9'd64) begin n_fail++; $display("[TB] FAIL prime1_fill got=%0d exp=64", fill); end
    n_checks++; if (suffix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL prime1_valid got=%b exp=0", suffix_valid); end
    in_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    in_valid = 0;
    n_checks++; if (fill !== 9'd128) begin n_fail++; $display("[TB] FAIL prime2_fill got=%0d exp=128", fill); end
    n_checks++; if (suffix_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL prime2_valid got=%b exp=1", suffix_valid); end
    n_checks++; if (suffix !== 128'hF0F0F0F0F0F0F0F0_123456789ABCDEF0) begin
      n_fail++; $display("[TB] FAIL prime2_suffix got=%h exp=f0f0f0f0f0f0f0f0123456789abcdef0", suffix); end
  endtask

  task automatic test_consume_append();
    logic [127:0] old_win;
    logic [127:0] exp_win;
    old_win = 128'hF0F0F0F0F0F0F0F0_123456789ABCDEF0;
    exp_win = (old_win << 5) | 128'h1F;
    consume_valid = 1; consume_bits = 8'd5;
    in_valid = 1; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle_inputs();
    n_checks++; if (fill !== 9'd187) begin n_fail++; $display("[TB] FAIL ca_fill got=%0d exp=187", fill); end
    n_checks++; if (bit_pos !== 24'd5) begin n_fail++; $display("[TB] FAIL ca_bit_pos got=%0d exp=5", bit_pos); end
    n_checks++; if (suffix !== exp_win) begin n_fail++; $display("[TB] FAIL ca_suffix got=%h exp=%h", suffix, exp_win); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = {$urandom, $urandom};
      tick();
    end
    n_checks++; if (fill !== 9'd256) begin n_fail++; $display("[TB] FAIL bp_full_fill got=%0d exp=256", fill); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full_ready got=%b exp=0", in_ready); end
    in_data = 64'hA5C3_0F1E_DEAD_BEEF;
    tick();
    n_checks++; if (fill !== 9'd256) begin n_fail++; $display("[TB] FAIL bp_hold_fill got=%0d exp=256", fill); end
    consume_valid = 1; consume_bits = 8'd100;
    tick();
    consume_valid = 0; consume_bits = '0;
    n_checks++; if (fill !== 9'd156) begin n_fail++; $display("[TB] FAIL bp_drain_fill got=%0d exp=156", fill); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_drain_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    n_checks++; if (fill !== 9'd220) begin n_fail++; $display("[TB] FAIL bp_append_fill got=%0d exp=220", fill); end
    n_checks++; if (suffix !== model_suffix()) begin n_fail++; $display("[TB] FAIL bp_suffix got=%h exp=%h", suffix, model_suffix()); end
  endtask

  task automatic test_illegal();
    logic [127:0] win_before;
    consume_valid = 1; consume_bits = 8'd20;
    tick();
    n_checks++; if (fill !== 9'd200) begin n_fail++; $display("[TB] FAIL ill_pre_fill got=%0d exp=200", fill); end
    consume_bits = 8'd129;
    tick();
    consume_valid = 0;
    n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ill129_err got=%b exp=1", err_overrun); end
    n_checks++; if (fill !== 9'd200) begin n_fail++; $display("[TB] FAIL ill129_fill got=%0d exp=200", fill); end
    n_checks++; if (bit_pos !== 24'd120) begin n_fail++; $display("[TB] FAIL ill129_pos got=%0d exp=120", bit_pos); end
    // Consume the full window so the held word from backpressure becomes visible
    consume_valid = 1; consume_bits = 8'd128;
    tick();
    consume_valid = 0;
    n_checks++; if (fill !== 9'd72) begin n_fail++; $display("[TB] FAIL ill_drain_fill got=%0d exp=72", fill); end
    n_checks++; if (suffix !== model_suffix()) begin n_fail++; $display("[TB] FAIL ill_drain_suffix got=%h exp=%h", suffix, model_suffix()); end
    do_reset();
    in_valid = 1; in_data = {$urandom, $urandom};
    tick();
    in_valid = 0;
    win_before = suffix;
    consume_valid = 1; consume_bits = 8'd10;
    tick();
    consume_valid = 0;
    n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ill64_err got=%b exp=1", err_overrun); end
    n_checks++; if (fill !== 9'd64) begin n_fail++; $display("[TB] FAIL ill64_fill got=%0d exp=64", fill); end
    n_checks++; if (suffix !== model_suffix()) begin n_fail++; $display("[TB] FAIL ill64_suffix got=%h exp=%h", suffix, model_suffix()); end
    n_checks++; if (bit_pos !== '0) begin n_fail++; $display("[TB] FAIL ill64_pos got=%0d exp=0", bit_pos); end
    if (win_before === 128'd0) $display("[TB] note: random word was zero");
  endtask

  task automatic test_clear();
    in_valid = 1; in_data = {$urandom, $urandom};
    tick();
    n_checks++; if (fill !== 9'd128) begin n_fail++; $display("[TB] FAIL clr_pre_fill got=%0d exp=128", fill); end
    clear = 1; consume_valid = 1; consume_bits = 8'd7; in_data = 64'hFFFF_0000_FFFF_0000;
    tick();
    idle_inputs();
    n_checks++; if (fill !== 9'd0) begin n_fail++; $display("[TB] FAIL clr_fill got=%0d exp=0", fill); end
    n_checks++; if (bit_pos !== '0) begin n_fail++; $display("[TB] FAIL clr_pos got=%0d exp=0", bit_pos); end
    n_checks++; if (suffix !== 128'd0) begin n_fail++; $display("[TB] FAIL clr_suffix got=%h exp=0", suffix); end
    n_checks++; if (err_overrun !== merr) begin n_fail++; $display("[TB] FAIL clr_err got=%b exp=%b", err_overrun, merr); end
  endtask

  task automatic test_async_reset();
    in_valid = 1; in_data = {$urandom, $urandom};
    tick();
    tick();
    in_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (fill !== 9'd0) begin n_fail++; $display("[TB] FAIL areset_fill got=%0d exp=0", fill); end
    n_checks++; if (suffix !== 128'd0) begin n_fail++; $display("[TB] FAIL areset_suffix got=%h exp=0", suffix); end
    n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_err got=%b exp=0", err_overrun); end
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_stream();
    bit sent[$];
    bit got[$];
    int cycles;
    int cb;
    bit holding;
    bit stream_ok;
    int first_bad;
    do_reset();
    holding = 0;
    cycles  = 0;
    while ((sent.size() < 10240 || mq.size() >= 128) && cycles < 5000) begin
      if (!holding) begin
        in_valid = (sent.size() < 10240) && ($urandom_range(0, 9) < 7);
        in_data  = {$urandom, $urandom};
      end
      consume_valid = 0; consume_bits = '0;
      if (mq.size() >= 128 && $urandom_range(0, 3) != 0) begin
        cb = $urandom_range(1, 128);
        consume_valid = 1; consume_bits = 8'(cb);
        for (int i = 0; i < cb; i++) got.push_back(suffix[127-i]);
      end
      if (in_valid && mq.size() <= BUF_W - IN_W) begin
        for (int i = IN_W-1; i >= 0; i--) sent.push_back(in_data[i]);
        holding = 0;
      end else begin
        holding = in_valid;
      end
      tick();
      cycles++;
      n_checks++; if (suffix !== model_suffix()) begin n_fail++; $display("[TB] FAIL rnd_suffix cyc=%0d got=%h exp=%h", cycles, suffix, model_suffix()); end
      n_checks++; if (fill !== 9'(mq.size())) begin n_fail++; $display("[TB] FAIL rnd_fill cyc=%0d got=%0d exp=%0d", cycles, fill, mq.size()); end
      n_checks++; if (bit_pos !== model_pos()) begin n_fail++; $display("[TB] FAIL rnd_pos cyc=%0d got=%0d exp=%0d", cycles, bit_pos, model_pos()); end
      n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_err cyc=%0d got=%b exp=0", cycles, err_overrun); end
    end
    idle_inputs();
    n_checks++; if (cycles >= 5000) begin n_fail++; $display("[TB] FAIL rnd_timeout cycles=%0d limit=5000", cycles); end
    n_checks++; if (got.size() < 10000) begin n_fail++; $display("[TB] FAIL rnd_consumed_count got=%0d exp>=10000", got.size()); end
    stream_ok = 1; first_bad = -1;
    for (int i = 0; i < got.size(); i++) begin
      if (i >= sent.size() || got[i] !== sent[i]) begin
        if (stream_ok) first_bad = i;
        stream_ok = 0;
      end
    end
    n_checks++; if (!stream_ok) begin n_fail++; $display("[TB] FAIL rnd_stream first_bad_bit=%0d exp=none", first_bad); end
    n_checks++; if (bit_pos !== POS_W'(got.size())) begin n_fail++; $display("[TB] FAIL rnd_total_pos got=%0d exp=%0d", bit_pos, got.size()); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_prime();
    test_consume_append();
    test_backpressure();
    test_illegal();
    test_clear();
    test_async_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
